// File: rtl/mmio_tx_fifo_slot.sv
// rtl/mmio_tx_fifo_slot.sv - MMIO transmit FIFO slot with drain stream and level interrupt
// Register writes push words into a circular buffer; the head drains on a valid/ready stream.
module mmio_tx_fifo_slot #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic [W-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          irq
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [4:0] A_TX_DATA = 5'd0;
  localparam logic [4:0] A_STATUS  = 5'd1;
  localparam logic [4:0] A_CTRL    = 5'd2;
  localparam logic [4:0] A_CMD     = 5'd3;
  localparam logic [4:0] A_THRESH  = 5'd4;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  logic [1:0]    r_ctrl;
  logic [AW:0]   r_thresh;

  logic          w_we;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_ovf_clr;
  logic          w_empty;
  logic          w_full;
  logic [31:0]   w_status;
  logic          w_unused;

  // Reads are side-effect free, so the read strobe is intentionally ignored.
  assign w_unused   = read;

  assign w_we       = cs & write;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_push_req = w_we & (addr == A_TX_DATA);
  assign w_push     = w_push_req & ~w_full;
  assign w_flush    = w_we & (addr == A_CMD) & wr_data[0];
  assign w_ovf_clr  = w_we & (addr == A_CMD) & wr_data[1];

  assign m_valid    = r_ctrl[0] & ~w_empty;
  assign m_data     = r_mem[r_rd_ptr];
  assign w_pop      = m_valid & m_ready;
  assign irq        = r_ctrl[1] & ((r_count <= r_thresh) | r_ovf);

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem[r_wr_ptr] <= wr_data[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_ctrl   <= '0;
      r_thresh <= '0;
    end else begin
      // Flush wins over any pop landing on the same edge.
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (AW+1)'(1);
          2'b01:   r_count <= r_count - (AW+1)'(1);
          default: r_count <= r_count;
        endcase
      end

      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end

      if (w_we && addr == A_CTRL) begin
        r_ctrl <= wr_data[1:0];
      end
      if (w_we && addr == A_THRESH) begin
        r_thresh <= wr_data[AW:0];
      end
    end
  end

  always_comb begin
    w_status         = '0;
    w_status[8+AW:8] = r_count;
    w_status[3]      = irq;
    w_status[2]      = r_ovf;
    w_status[1]      = w_full;
    w_status[0]      = w_empty;

    rd_data = '0;
    case (addr)
      A_STATUS: rd_data = w_status;
      A_CTRL:   rd_data[1:0] = r_ctrl;
      A_THRESH: rd_data[AW:0] = r_thresh;
      default:  rd_data = '0;
    endcase
  end

endmodule
